// File: rtl/seq_cska_add64_pkg.sv
// seq_cska_add64_pkg: shared types and helpers for the sequential carry-skip adder.
//   state_t  : controller FSM states (IDLE, RUN, DONE)
//   SKIP_W   : width of one carry-skip block inside the adder slice
//   width_ok : true when the operand width splits evenly into slices
package seq_cska_add64_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SKIP_W = 4;

    function automatic bit width_ok(input int op_w, input int slice_w);
        return (slice_w > 0) && (op_w >= slice_w) && ((op_w % slice_w) == 0);
    endfunction

endpackage

// File: rtl/seq_cska_add64_cska_slice.sv
// cska_slice: combinational W-bit carry-skip adder with carry-in and carry-out.
//   i_a, i_b : W-bit addends
//   i_cin    : carry into bit 0
//   o_sum    : W-bit sum
//   o_cout   : carry out of bit W-1
// The slice is cut into BLK-bit blocks. Each block ripples internally; when
// every bit of a block propagates, the block carry-in skips straight to the
// block output instead of waiting for the ripple.
module cska_slice
    import seq_cska_add64_pkg::*;
#(
    parameter int W   = 16,
    parameter int BLK = SKIP_W
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_cin,
    output logic [W-1:0] o_sum,
    output logic         o_cout
);

    localparam int NBLK = W / BLK;

    logic [W-1:0] w_sum;
    logic         w_c;
    logic         w_bcin;
    logic         w_pall;
    logic         w_p;

    always_comb begin
        w_sum  = '0;
        w_c    = i_cin;
        w_bcin = 1'b0;
        w_pall = 1'b0;
        w_p    = 1'b0;
        for (int k = 0; k < NBLK; k++) begin
            w_bcin = w_c;
            w_pall = 1'b1;
            for (int j = 0; j < BLK; j++) begin
                w_p                = i_a[k*BLK+j] ^ i_b[k*BLK+j];
                w_sum[k*BLK+j]     = w_p ^ w_c;
                w_c                = (i_a[k*BLK+j] & i_b[k*BLK+j]) | (w_p & w_c);
                w_pall             = w_pall & w_p;
            end
            // skip mux: a fully propagating block passes its carry-in through
            w_c = w_pall ? w_bcin : w_c;
        end
    end

    assign o_sum  = w_sum;
    assign o_cout = w_c;

endmodule

// File: rtl/seq_cska_add64.sv
// seq_cska_add64: multi-cycle unsigned adder, one SLICE_W-bit carry-skip slice per clock.
//   i_clk        : clock, rising edge
//   i_rst_n      : synchronous active-low reset
//   i_in_valid   : operands present          o_in_ready  : can accept operands
//   i_a, i_b     : OP_WIDTH-bit operands      i_cin       : carry into bit 0
//   o_out_valid  : result present             i_out_ready : downstream takes result
//   o_out_sum    : OP_WIDTH+1-bit sum, MSB is the final carry-out
//   o_busy       : high while computing or holding a result
// Operands are shifted right one slice per RUN cycle so the slice always sees
// the low SLICE_W bits; the result is shifted in from the top so that after
// NSLICE cycles slice k sits at bits [k*SLICE_W +: SLICE_W].
module seq_cska_add64
    import seq_cska_add64_pkg::*;
#(
    parameter int OP_WIDTH = 64,
    parameter int SLICE_W  = 16
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_in_valid,
    output logic                o_in_ready,
    input  logic [OP_WIDTH-1:0] i_a,
    input  logic [OP_WIDTH-1:0] i_b,
    input  logic                i_cin,
    output logic                o_out_valid,
    input  logic                i_out_ready,
    output logic [OP_WIDTH:0]   o_out_sum,
    output logic                o_busy
);

    localparam int NSLICE = OP_WIDTH / SLICE_W;
    localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);

    if (!width_ok(OP_WIDTH, SLICE_W)) begin : g_bad_width
        $error("seq_cska_add64: OP_WIDTH must be a non-zero multiple of SLICE_W");
    end

    state_t                r_state;
    state_t                w_next;
    logic [OP_WIDTH-1:0]   r_a;
    logic [OP_WIDTH-1:0]   r_b;
    logic [OP_WIDTH-1:0]   r_res;
    logic                  r_carry;
    logic [IW-1:0]         r_idx;
    logic                  r_out_valid;
    logic [OP_WIDTH:0]     r_out_sum;
    logic [SLICE_W-1:0]    w_s;
    logic                  w_co;

    cska_slice #(
        .W   (SLICE_W),
        .BLK (SKIP_W)
    ) u_slice (
        .i_a    (r_a[SLICE_W-1:0]),
        .i_b    (r_b[SLICE_W-1:0]),
        .i_cin  (r_carry),
        .o_sum  (w_s),
        .o_cout (w_co)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    w_next = i_in_valid ? RUN : IDLE;
            RUN:     w_next = (r_idx == LAST) ? DONE : RUN;
            DONE:    w_next = i_out_ready ? IDLE : DONE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        o_in_ready = (r_state == IDLE) & i_rst_n;
        o_busy     = (r_state == RUN) | (r_state == DONE);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_a         <= '0;
            r_b         <= '0;
            r_res       <= '0;
            r_carry     <= 1'b0;
            r_idx       <= '0;
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (i_in_valid) begin
                        r_a     <= i_a;
                        r_b     <= i_b;
                        r_carry <= i_cin;
                        r_idx   <= '0;
                        r_res   <= '0;
                    end
                end
                RUN: begin
                    r_a     <= r_a >> SLICE_W;
                    r_b     <= r_b >> SLICE_W;
                    r_carry <= w_co;
                    r_res   <= {w_s, r_res[OP_WIDTH-1:SLICE_W]};
                    r_idx   <= (r_idx == LAST) ? '0 : r_idx + 1'b1;
                    if (r_idx == LAST) begin
                        r_out_valid <= 1'b1;
                        r_out_sum   <= {w_co, w_s, r_res[OP_WIDTH-1:SLICE_W]};
                    end
                end
                DONE: begin
                    if (i_out_ready)
                        r_out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_out_sum   = r_out_sum;

endmodule

// File: doc/seq_cska_add64.md
Name: seq_cska_add64

Overview:
- Multi-cycle wide unsigned adder that drives one 16-bit carry-skip adder slice with carry-in.
- Accepts two OP_WIDTH operands plus carry-in over a valid/ready handshake.
- Adds them least-significant slice first, one slice per clock, with the slice carry-out registered and fed back as the next carry-in.
- Presents an (OP_WIDTH+1)-bit sum on a valid/ready output; sits directly upstream of, and consumes, the carry-skip adder core.

Parameters:
- OP_WIDTH, 64, operand width in bits; must be a multiple of SLICE_W.
- SLICE_W, 16, width of the carry-skip adder slice used per cycle.
- NSLICE, OP_WIDTH/SLICE_W (derived localparam, not overridable), number of compute cycles.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands.
- a  input  OP_WIDTH  operand A, unsigned.
- b  input  OP_WIDTH  operand B, unsigned.
- cin  input  1  carry-in to bit 0.
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts result.
- out_sum  output  OP_WIDTH+1  result; MSB is final carry-out.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (rst_n low at a rising edge): state=IDLE; out_valid=0, out_sum=0, busy=0, slice index=0, carry register=0, operand registers=0.
  - in_ready is gated to 0 while rst_n is low, including mid-operation; any in-flight operation is discarded without producing output.
- FSM states IDLE, RUN, DONE; in_ready = (state==IDLE) & rst_n.
- IDLE, with in_valid & in_ready at an edge:
  - latch a, b; carry register <= cin; index <= 0; result register <= 0; go to RUN.
- RUN, each edge:
  - slice k = index computes {co, s} = a[k*SLICE_W +: SLICE_W] + b[same] + carry (registered operand copies only).
  - result[k*SLICE_W +: SLICE_W] <= s; carry <= co.
  - if k == NSLICE-1: go to DONE, out_valid <= 1, out_sum <= {co, result with slice k}; else index <= k+1.
- DONE:
  - out_valid and out_sum held stable until out_valid & out_ready at an edge.
  - on that edge: out_valid <= 0, go to IDLE. out_sum keeps its last value after the handshake.
- Latency and throughput:
  - out_valid rises exactly NSLICE edges after the accept edge (4 for defaults).
  - Minimum initiation interval is NSLICE+2 cycles: no accept in the same cycle as output handshake, because in_ready is 0 in DONE.
- Handshake rules:
  - in_valid/a/b/cin are ignored outside IDLE.
  - Input changes after acceptance do not affect the result.
  - out_ready is ignored outside DONE; out_ready held high permanently is legal.
- Arithmetic: pure unsigned, result = a + b + cin exactly, no saturation. The all-ones case is required: a=b=2^64-1, cin=1 gives out_sum = 2^65-1.
- Width rules:
  - out_sum[OP_WIDTH] is the carry-out of the last slice only.
  - Intermediate carries never leave the block.
- Boundary: carry must ripple correctly across every slice boundary, including a propagate chain spanning all slices (a=all-ones, b=0, cin=1).

Decomposition:
- Shared package: FSM state enum {IDLE, RUN, DONE} and a width-check function, so an elaboration-time assertion fires when OP_WIDTH % SLICE_W != 0.
- One sub-module: cska_slice, a combinational SLICE_W-bit carry-skip adder with cin and cout, 4-bit skip blocks.
  - Its skip mux selects the block carry-in when all block propagates are 1, otherwise the block's ripple carry-out.
  - Instantiated once; the controller registers its inputs and outputs.

Test Plan:
- Reset then a=1, b=2, cin=0 accepted with out_ready=1 -> out_valid rises 4 edges after accept, out_sum=3; in_ready returns high 1 cycle after the handshake.
- a=0xFFFF_FFFF_FFFF_FFFF, b=0, cin=1 -> out_sum=0x1_0000_0000_0000_0000 (full propagate/skip chain across all slices).
- a=b=0xFFFF_FFFF_FFFF_FFFF, cin=1 -> out_sum=0x1_FFFF_FFFF_FFFF_FFFF.
- a=0x0000_FFFF_0000_FFFF, b=1, cin=0, out_ready low for 5 cycles -> out_sum=0x0_0000_FFFF_0001_0000 stable and out_valid held for all 5 cycles; in_valid pulses during DONE are ignored.
- rst_n low during RUN index 2 -> next cycle out_valid=0, busy=0, out_sum=0, in_ready=1 once rst_n is high; next operation a=5, b=7 -> 12.
- 10,000 random a/b/cin with random out_ready stalls -> every out_sum equals the reference sum and results arrive in issue order.
